board_controller: RTL and testbench
===================================

BOARD_CONTROLLER -- requirements
Module: board_controller

Interface
REQ-001 SHALL provide parameter FIRST_PLAYER, default 0, meaning the side that moves first after reset/restart (0 = X, 1 = O).
REQ-002 SHALL provide port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous, active-low, sampled on the clk rising edge.
REQ-004 SHALL provide port position  input  4  cursor cell index, 0..8 row-major (0:1:2 / 3:4:5 / 6:7:8); values 9..15 are invalid.
REQ-005 SHALL provide port select  input  1  place-mark button level, already synchronized and debounced.
REQ-006 SHALL provide port restart  input  1  new-game request, level-sampled.
REQ-007 SHALL provide port board  output  18  cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O; 11 never driven.
REQ-008 SHALL provide port turn  output  1  side to move (0 = X, 1 = O).
REQ-009 SHALL provide port winner  output  2  00 none, 01 X, 10 O, 11 draw.
REQ-010 SHALL provide port game_over  output  1  high while in DONE.
REQ-011 SHALL provide port move_err  output  1  one-cycle pulse on a rejected move.
REQ-012 All outputs SHALL be registered.

Function
REQ-013 SHALL register select into select_q each cycle; move request = select high and select_q low at the same edge.
REQ-014 SHALL implement states PLAY, CHECK, DONE.
REQ-015 PLAY, request, position <= 8, cell empty: write turn's mark into that cell at that edge, go to CHECK.
REQ-016 PLAY, request, position >= 9 or cell occupied: board unchanged, move_err high for exactly the next cycle, stay in PLAY.
REQ-017 CHECK lasts exactly one cycle; evaluates 3 rows, 3 columns, 2 diagonals for three equal non-empty marks.
REQ-018 CHECK, line complete: winner = mark of the side that just moved, game_over = 1, go to DONE, turn unchanged.
REQ-019 CHECK, no line, all 9 cells non-empty: winner = 11, game_over = 1, go to DONE.
REQ-020 CHECK, otherwise: toggle turn, go to PLAY.
REQ-021 Latency: request accepted at edge k -> board updated after edge k; turn/winner/game_over updated after edge k+1.
REQ-022 Requests arriving while in CHECK or DONE SHALL be dropped (no board change, no move_err); select_q still updates.
REQ-023 restart high at any edge in any state: board = 0, turn = FIRST_PLAYER, winner = 00, game_over = 0, move_err = 0, state = PLAY.
REQ-024 restart and request at the same edge: restart wins; the move is discarded.
REQ-025 A held select SHALL produce exactly one request; the next requires select to return low for at least one cycle.
REQ-026 position SHALL be sampled only at the request edge; changes at other times have no effect.
REQ-027 A win formed on the ninth move SHALL report the winning side, not draw.

Reset
REQ-028 rst_n low at an edge: board = 0, turn = FIRST_PLAYER, winner = 00, game_over = 0, move_err = 0, state = PLAY, select_q = 1.
REQ-029 select_q reset to 1 SHALL prevent a select held through reset release from generating a request.
REQ-030 rst_n takes priority over restart and over any request at the same edge.
REQ-031 Reset mid-CHECK SHALL discard the pending evaluation; board clears.

Verification
REQ-032 X plays 0,3,1,4,2 (O on 3,4) -> after the fifth move: winner = 01, game_over = 1, turn = 0, board[5:0] = 010101.
REQ-033 Pulse select at position 4 twice, second when O to move -> second: move_err pulses 1 cycle, board[9:8] = 01, turn stays 1.
REQ-034 position = 12 with select rise -> move_err = 1 for one cycle, board = 0.
REQ-035 Draw sequence 0,1,2,4,3,5,7,6,8 -> winner = 11, game_over = 1; further select rises ignored, no move_err.
REQ-036 Hold select high 20 cycles in PLAY -> exactly one mark placed; select held through reset release -> no mark placed.
REQ-037 restart asserted in DONE and mid-game, also coincident with a select rise -> board = 0, turn = FIRST_PLAYER, winner = 00, no mark placed.

Source files
------------

// File: rtl/board_controller.sv
// Tic-tac-toe board controller: accepts edge-detected moves, checks for wins and draws
// one cycle after each placement, and reports the result on registered outputs.
module board_controller #(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  position,
    input  logic        select,
    input  logic        restart,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        move_err
);

    typedef enum logic [1:0] {StPlay, StCheck, StDone} state_e;

    state_e      state_q;
    logic [17:0] board_q;
    logic        turn_q;
    logic [1:0]  winner_q;
    logic        game_over_q;
    logic        move_err_q;
    logic        select_q;

    logic [1:0]  cells [9];
    logic [1:0]  cell_at_pos;
    logic [1:0]  mark;
    logic        request;
    logic        pos_valid;
    logic        line_found;
    logic        board_full;

    function automatic logic three_equal(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c);
        return (a != 2'b00) && (a == b) && (b == c);
    endfunction

    assign request   = select && !select_q;
    assign pos_valid = (position <= 4'd8);
    assign mark      = turn_q ? 2'b10 : 2'b01;

    always_comb begin
        cell_at_pos = 2'b00;
        board_full  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cells[i] = board_q[2*i +: 2];
            if (cells[i] == 2'b00) board_full = 1'b0;
            if (position == 4'(i)) cell_at_pos = cells[i];
        end
    end

    always_comb begin
        line_found = three_equal(cells[0], cells[1], cells[2])
                   | three_equal(cells[3], cells[4], cells[5])
                   | three_equal(cells[6], cells[7], cells[8])
                   | three_equal(cells[0], cells[3], cells[6])
                   | three_equal(cells[1], cells[4], cells[7])
                   | three_equal(cells[2], cells[5], cells[8])
                   | three_equal(cells[0], cells[4], cells[8])
                   | three_equal(cells[2], cells[4], cells[6]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StPlay;
            board_q     <= '0;
            turn_q      <= FIRST_PLAYER;
            winner_q    <= 2'b00;
            game_over_q <= 1'b0;
            move_err_q  <= 1'b0;
            // Starts high so a button held through reset release is not seen as a press.
            select_q    <= 1'b1;
        end else begin
            select_q   <= select;
            move_err_q <= 1'b0;
            if (restart) begin
                state_q     <= StPlay;
                board_q     <= '0;
                turn_q      <= FIRST_PLAYER;
                winner_q    <= 2'b00;
                game_over_q <= 1'b0;
            end else begin
                case (state_q)
                    StPlay: begin
                        if (request) begin
                            if (pos_valid && (cell_at_pos == 2'b00)) begin
                                board_q[{position, 1'b0} +: 2] <= mark;
                                state_q <= StCheck;
                            end else begin
                                move_err_q <= 1'b1;
                            end
                        end
                    end
                    StCheck: begin
                        // A line can only belong to the side that just moved, so it
                        // outranks a full board.
                        if (line_found) begin
                            winner_q    <= mark;
                            game_over_q <= 1'b1;
                            state_q     <= StDone;
                        end else if (board_full) begin
                            winner_q    <= 2'b11;
                            game_over_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            turn_q  <= ~turn_q;
                            state_q <= StPlay;
                        end
                    end
                    StDone: begin
                    end
                    default: state_q <= StPlay;
                endcase
            end
        end
    end

    assign board     = board_q;
    assign turn      = turn_q;
    assign winner    = winner_q;
    assign game_over = game_over_q;
    assign move_err  = move_err_q;

endmodule

// File: tb/tb_board_controller.sv
// Directed test of board_controller: wins, draws, rejected moves, held select,
// restart and reset behaviour, with expected values computed by hand or a tiny board model.
module tb_board_controller;

    logic        clk;
    logic        rst_n;
    logic [3:0]  position;
    logic        select;
    logic        restart;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  winner;
    logic        game_over;
    logic        move_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_board;
    logic        exp_turn;
    logic        e1, e2;

    logic [3:0] win_seq   [5] = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
    logic [3:0] draw_seq  [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    logic [3:0] ninth_seq [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd6, 4'd8};

    board_controller #(.FIRST_PLAYER(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .position  (position),
        .select    (select),
        .restart   (restart),
        .board     (board),
        .turn      (turn),
        .winner    (winner),
        .game_over (game_over),
        .move_err  (move_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press at edge k, release for edge k+1; returns with turn/winner settled.
    task automatic do_move(input logic [3:0] p, output logic err1, output logic err2);
        @(negedge clk);
        position = p;
        select   = 1'b1;
        @(negedge clk);
        err1   = move_err;
        select = 1'b0;
        @(negedge clk);
        err2 = move_err;
    endtask

    task automatic model_move(input logic [3:0] p);
        exp_board[2*p +: 2] = exp_turn ? 2'b10 : 2'b01;
        exp_turn = ~exp_turn;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        exp_board = '0;
        exp_turn  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        select   = 1'b1;
        restart  = 1'b1;
        position = 4'd0;
        exp_board = '0;
        exp_turn  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_board", 32'(board), 32'h0);
        check("reset_turn", 32'(turn), 32'h0);
        check("reset_winner", 32'(winner), 32'h0);
        check("reset_game_over", 32'(game_over), 32'h0);
        check("reset_move_err", 32'(move_err), 32'h0);

        // Select held through reset release must not place a mark.
        restart = 1'b0;
        rst_n   = 1'b1;
        repeat (5) @(negedge clk);
        check("held_through_reset_board", 32'(board), 32'h0);
        select = 1'b0;
        @(negedge clk);

        // Latency: board after edge k, turn after edge k+1.
        position = 4'd0;
        select   = 1'b1;
        @(negedge clk);
        check("lat_board_after_k", 32'(board), 32'h1);
        check("lat_turn_after_k", 32'(turn), 32'h0);
        select = 1'b0;
        @(negedge clk);
        check("lat_turn_after_k1", 32'(turn), 32'h1);
        model_move(4'd0);

        for (int i = 1; i < 5; i++) begin
            do_move(win_seq[i], e1, e2);
            model_move(win_seq[i]);
        end
        check("row_win_winner", 32'(winner), 32'h1);
        check("row_win_game_over", 32'(game_over), 32'h1);
        check("row_win_turn", 32'(turn), 32'h0);
        check("row_win_board_lo", 32'(board[5:0]), 32'h15);
        check("row_win_board", 32'(board), 32'(exp_board));

        // Moves in DONE are dropped silently.
        do_move(4'd8, e1, e2);
        check("done_drop_err", 32'(e1), 32'h0);
        check("done_drop_board", 32'(board), 32'(exp_board));

        do_restart();
        check("restart_done_board", 32'(board), 32'h0);
        check("restart_done_winner", 32'(winner), 32'h0);
        check("restart_done_game_over", 32'(game_over), 32'h0);
        check("restart_done_turn", 32'(turn), 32'h0);

        // Occupied cell rejected.
        do_move(4'd4, e1, e2);
        check("occ_first_board", 32'(board[9:8]), 32'h1);
        check("occ_first_turn", 32'(turn), 32'h1);
        do_move(4'd4, e1, e2);
        check("occ_err_pulse", 32'(e1), 32'h1);
        check("occ_err_cleared", 32'(e2), 32'h0);
        check("occ_board", 32'(board[9:8]), 32'h1);
        check("occ_turn", 32'(turn), 32'h1);

        do_restart();
        do_move(4'd12, e1, e2);
        check("invalid_pos_err_pulse", 32'(e1), 32'h1);
        check("invalid_pos_err_cleared", 32'(e2), 32'h0);
        check("invalid_pos_board", 32'(board), 32'h0);
        check("invalid_pos_turn", 32'(turn), 32'h0);

        do_restart();
        for (int i = 0; i < 9; i++) begin
            do_move(draw_seq[i], e1, e2);
            model_move(draw_seq[i]);
        end
        check("draw_winner", 32'(winner), 32'h3);
        check("draw_game_over", 32'(game_over), 32'h1);
        check("draw_board", 32'(board), 32'(exp_board));
        do_move(4'd0, e1, e2);
        check("draw_drop_err1", 32'(e1), 32'h0);
        check("draw_drop_err2", 32'(e2), 32'h0);
        check("draw_drop_board", 32'(board), 32'(exp_board));

        do_restart();
        for (int i = 0; i < 9; i++) begin
            do_move(ninth_seq[i], e1, e2);
            model_move(ninth_seq[i]);
        end
        check("ninth_win_winner", 32'(winner), 32'h1);
        check("ninth_win_game_over", 32'(game_over), 32'h1);
        check("ninth_win_board", 32'(board), 32'(exp_board));

        // Held select: one mark; position changes after the request edge are ignored.
        do_restart();
        @(negedge clk);
        position = 4'd5;
        select   = 1'b1;
        @(negedge clk);
        position = 4'd6;
        repeat (19) @(negedge clk);
        check("held_select_board", 32'(board), 32'h400);
        check("held_select_turn", 32'(turn), 32'h1);
        select = 1'b0;
        @(negedge clk);

        // Mid-game restart coincident with a select rise.
        position = 4'd0;
        select   = 1'b1;
        restart  = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_sel_board", 32'(board), 32'h0);
        check("restart_sel_turn", 32'(turn), 32'h0);
        check("restart_sel_winner", 32'(winner), 32'h0);
        repeat (3) @(negedge clk);
        check("restart_sel_held_board", 32'(board), 32'h0);
        select = 1'b0;
        @(negedge clk);

        // Reset during CHECK discards the evaluation; reset outranks restart.
        do_move(4'd2, e1, e2);
        position = 4'd0;
        select   = 1'b1;
        @(negedge clk);
        check("pre_reset_board", 32'(board), 32'h12);
        rst_n   = 1'b0;
        restart = 1'b1;
        select  = 1'b0;
        @(negedge clk);
        check("reset_check_board", 32'(board), 32'h0);
        check("reset_check_turn", 32'(turn), 32'h0);
        check("reset_check_game_over", 32'(game_over), 32'h0);
        rst_n   = 1'b1;
        restart = 1'b0;
        @(negedge clk);
        check("post_reset_turn", 32'(turn), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
